udp_packet_rx: RTL and testbench

- GMII-side receiver for the FPGA UDP/IPv4 stream; counterpart of the Ethernet/IP/UDP transmit path.
- Detects preamble/SFD and parses the fixed 42-byte header (14 Ethernet + 20 IPv4 + 8 UDP).
- Filters frames on local MAC/IP/port, streams the UDP payload to an AXI-Stream master, and flags the last beat with a CRC-32/length/overflow error bit.
- Sits between the RGMII-to-GMII converter and user payload logic.

---
 rtl/udp_packet_rx.sv | 266 ++++++++++++++++++++++++++
 tb/tb_udp_packet_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_packet_rx.sv
// GMII receive path for the UDP/IPv4 stream: preamble/SFD detection, 42-byte header
// parse and filter, payload forwarding on AXI-Stream with a CRC/length/overflow error flag.
module udp_packet_rx #(
    parameter int PAYLOAD_WIDTH = 11,
    parameter int GMII_WIDTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     rx_dv_i,
    input  logic                     rx_er_i,
    input  logic [GMII_WIDTH-1:0]    rx_d_i,
    input  logic [47:0]              fpga_mac_i,
    input  logic [31:0]              fpga_ip_i,
    input  logic [15:0]              fpga_port_i,
    output logic [GMII_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    input  logic                     m_axis_tready,
    output logic [47:0]              host_mac_o,
    output logic [31:0]              host_ip_o,
    output logic [15:0]              host_port_o,
    output logic [PAYLOAD_WIDTH-1:0] payload_bytes_o,
    output logic                     frame_done_o,
    output logic                     drop_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_TRAILER, S_DROP, S_FLUSH
    } state_t;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [16:0] MAX_PAY     = 17'((1 << PAYLOAD_WIDTH) - 1);

    state_t state_q, state_d;

    logic [2:0]               pre_cnt_q;
    logic [5:0]               hdr_cnt_q;
    logic [327:0]             hdr_q;
    logic [335:0]             hdr_full;
    logic [31:0]              crc_q;
    logic [PAYLOAD_WIDTH-1:0] pay_cnt_q;
    logic [PAYLOAD_WIDTH-1:0] pay_bytes_q;
    logic                     err_q;
    logic [GMII_WIDTH-1:0]    pend_q;
    logic                     pend_vld_q;
    logic [GMII_WIDTH-1:0]    out_data_q;
    logic                     out_vld_q, out_last_q, out_user_q;
    logic [47:0]              host_mac_q;
    logic [31:0]              host_ip_q;
    logic [15:0]              host_port_q;
    logic                     drop_q;

    // FSM strobes
    logic crc_init, crc_en, hdr_take, hdr_accept, drop_pulse;
    logic pay_take, trunc, flush_move;
    logic out_free, pay_last, hdr_pass, len_ok;

    // Header fields; the last header byte is taken straight from the wire
    logic [47:0] f_dst_mac, f_src_mac;
    logic [15:0] f_etype, f_src_port, f_dst_port, f_udp_len, pl_len16;
    logic [7:0]  f_ver_ihl, f_proto;
    logic [31:0] f_src_ip, f_dst_ip;
    logic        unused_hdr;

    assign hdr_full   = {hdr_q, rx_d_i};
    assign f_dst_mac  = hdr_full[335:288];
    assign f_src_mac  = hdr_full[287:240];
    assign f_etype    = hdr_full[239:224];
    assign f_ver_ihl  = hdr_full[223:216];
    assign f_proto    = hdr_full[151:144];
    assign f_src_ip   = hdr_full[127:96];
    assign f_dst_ip   = hdr_full[95:64];
    assign f_src_port = hdr_full[63:48];
    assign f_dst_port = hdr_full[47:32];
    assign f_udp_len  = hdr_full[31:16];
    assign pl_len16   = f_udp_len - 16'd8;
    assign unused_hdr = ^{hdr_full[215:152], hdr_full[143:128], hdr_full[15:0], pl_len16};

    assign len_ok   = (f_udp_len >= 16'd9) && (({1'b0, f_udp_len} - 17'd8) <= MAX_PAY);
    assign hdr_pass = ((f_dst_mac == fpga_mac_i) || (f_dst_mac == 48'hFFFF_FFFF_FFFF)) &&
                      (f_etype == 16'h0800) && (f_ver_ihl == 8'h45) && (f_proto == 8'h11) &&
                      (f_dst_ip == fpga_ip_i) && (f_dst_port == fpga_port_i) && len_ok;

    assign out_free = !out_vld_q || m_axis_tready;
    assign pay_last = (pay_cnt_q + PAYLOAD_WIDTH'(1)) == pay_bytes_q;
    assign crc_en   = rx_dv_i && ((state_q == S_HEADER) || (state_q == S_PAYLOAD) ||
                                  (state_q == S_TRAILER));

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        crc_init   = 1'b0;
        hdr_take   = 1'b0;
        hdr_accept = 1'b0;
        drop_pulse = 1'b0;
        pay_take   = 1'b0;
        trunc      = 1'b0;
        flush_move = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_dv_i) state_d = (rx_d_i == 8'h55) ? S_PREAMBLE : S_DROP;
            end
            S_PREAMBLE: begin
                if (!rx_dv_i)
                    state_d = S_IDLE;
                else if (rx_d_i == 8'hD5) begin
                    state_d  = S_HEADER;
                    crc_init = 1'b1;
                end else if (!(rx_d_i == 8'h55 && pre_cnt_q < 3'd7))
                    state_d = S_DROP;
            end
            S_HEADER: begin
                if (!rx_dv_i) begin
                    state_d    = S_IDLE;
                    drop_pulse = 1'b1;
                end else begin
                    hdr_take = 1'b1;
                    if (hdr_cnt_q == 6'd41) begin
                        if (hdr_pass) begin
                            state_d    = S_PAYLOAD;
                            hdr_accept = 1'b1;
                        end else begin
                            state_d    = S_DROP;
                            drop_pulse = 1'b1;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (!rx_dv_i) begin
                    state_d = S_FLUSH;
                    trunc   = 1'b1;
                end else begin
                    pay_take = 1'b1;
                    if (pay_last) state_d = S_TRAILER;
                end
            end
            S_TRAILER: begin
                if (!rx_dv_i) state_d = S_FLUSH;
            end
            S_DROP: begin
                if (!rx_dv_i) state_d = S_IDLE;
            end
            S_FLUSH: begin
                // A frame that starts before the flush completes is discarded.
                if (pend_vld_q)
                    flush_move = out_free;
                else if (out_vld_q && out_last_q) begin
                    if (m_axis_tready) state_d = rx_dv_i ? S_DROP : S_IDLE;
                end else begin
                    drop_pulse = 1'b1;
                    state_d    = rx_dv_i ? S_DROP : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pre_cnt_q   <= '0;
            hdr_cnt_q   <= '0;
            hdr_q       <= '0;
            crc_q       <= '0;
            pay_cnt_q   <= '0;
            pay_bytes_q <= '0;
            err_q       <= 1'b0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            out_data_q  <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            host_mac_q  <= '0;
            host_ip_q   <= '0;
            host_port_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= drop_pulse;

            if (state_q == S_IDLE)          pre_cnt_q <= 3'd1;
            else if (state_q == S_PREAMBLE) pre_cnt_q <= pre_cnt_q + 3'd1;

            if (crc_init) begin
                crc_q     <= '1;
                hdr_cnt_q <= '0;
                err_q     <= 1'b0;
            end else if (crc_en) begin
                crc_q <= crc_byte(crc_q, rx_d_i);
                if (rx_er_i) err_q <= 1'b1;
            end

            if (hdr_take) begin
                hdr_q     <= {hdr_q[319:0], rx_d_i};
                hdr_cnt_q <= hdr_cnt_q + 6'd1;
            end

            if (hdr_accept) begin
                host_mac_q  <= f_src_mac;
                host_ip_q   <= f_src_ip;
                host_port_q <= f_src_port;
                pay_bytes_q <= pl_len16[PAYLOAD_WIDTH-1:0];
                pay_cnt_q   <= '0;
            end

            if (out_vld_q && m_axis_tready) begin
                out_vld_q  <= 1'b0;
                out_last_q <= 1'b0;
                out_user_q <= 1'b0;
            end

            // The newest byte always lands in pending; the older one advances to
            // the output register, or the new byte is lost if that is still full.
            if (pay_take) begin
                pay_cnt_q <= pay_cnt_q + PAYLOAD_WIDTH'(1);
                if (!pend_vld_q) begin
                    pend_q     <= rx_d_i;
                    pend_vld_q <= 1'b1;
                end else if (out_free) begin
                    out_data_q <= pend_q;
                    out_vld_q  <= 1'b1;
                    out_last_q <= 1'b0;
                    out_user_q <= 1'b0;
                    pend_q     <= rx_d_i;
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (trunc) err_q <= 1'b1;

            if (flush_move) begin
                out_data_q <= pend_q;
                out_vld_q  <= 1'b1;
                out_last_q <= 1'b1;
                out_user_q <= err_q || (crc_q != CRC_RESIDUE);
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata    = out_data_q;
    assign m_axis_tvalid   = out_vld_q;
    assign m_axis_tlast    = out_last_q;
    assign m_axis_tuser    = out_user_q;
    assign host_mac_o      = host_mac_q;
    assign host_ip_o       = host_ip_q;
    assign host_port_o     = host_port_q;
    assign payload_bytes_o = pay_bytes_q;
    assign frame_done_o    = out_vld_q && out_last_q && m_axis_tready;
    assign drop_o          = drop_q;

endmodule

// File: tb/tb_udp_packet_rx.sv
// Directed/randomized bench for udp_packet_rx: frames are built from header field
// values, payload expectations come from the generated payload and the frame rules.
module tb_udp_packet_rx;

    localparam int PW       = 11;
    localparam int NO_STALL = -1000;

    logic          clk = 1'b0;
    logic          rstn_i, rx_dv_i, rx_er_i, m_axis_tready;
    logic [7:0]    rx_d_i;
    logic [47:0]   fpga_mac;
    logic [31:0]   fpga_ip;
    logic [15:0]   fpga_port;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic [47:0]   host_mac_o;
    logic [31:0]   host_ip_o;
    logic [15:0]   host_port_o;
    logic [PW-1:0] payload_bytes_o;
    logic          frame_done_o, drop_o;

    udp_packet_rx #(.PAYLOAD_WIDTH(PW), .GMII_WIDTH(8)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .rx_dv_i(rx_dv_i), .rx_er_i(rx_er_i), .rx_d_i(rx_d_i),
        .fpga_mac_i(fpga_mac), .fpga_ip_i(fpga_ip), .fpga_port_i(fpga_port),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready), .host_mac_o(host_mac_o), .host_ip_o(host_ip_o),
        .host_port_o(host_port_o), .payload_bytes_o(payload_bytes_o),
        .frame_done_o(frame_done_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    int          done_cnt = 0, drop_cnt = 0, done0, drop0;
    logic [9:0]  got[$];    // {tlast, tuser, tdata}
    logic [7:0]  frm[$];    // bytes after SFD, FCS included
    logic [7:0]  pay[$];
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port;

    always @(negedge clk) begin
        if (rstn_i) begin
            if (m_axis_tvalid && m_axis_tready)
                got.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
            if (frame_done_o) done_cnt <= done_cnt + 1;
            if (drop_o)       drop_cnt <= drop_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [47:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
    endtask

    task automatic build(input logic [47:0] dmac, input logic [31:0] dip,
                         input logic [15:0] dport, input logic [7:0] proto,
                         input int n, input int pad, input bit rnd, input bit bad_fcs);
        logic [31:0] c;
        frm.delete();
        pay.delete();
        src_mac  = {16'($urandom), $urandom};
        src_ip   = $urandom;
        src_port = 16'($urandom);
        put(dmac, 6); put(src_mac, 6); put(48'h0800, 2);
        put(48'h45, 1); put(48'h0, 1); put(48'(n + 28), 2); put(48'h0, 4);
        put(48'h40, 1); put(48'(proto), 1); put(48'h0, 2);
        put(48'(src_ip), 4); put(48'(dip), 4); put(48'(src_port), 2); put(48'(dport), 2);
        put(48'(n + 8), 2); put(48'h0, 2);
        for (int i = 0; i < n; i++) begin
            pay.push_back(rnd ? 8'($urandom) : 8'(i));
            frm.push_back(pay[i]);
        end
        for (int i = 0; i < pad; i++) frm.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (frm[k]) begin
            c ^= {24'h0, frm[k]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        if (bad_fcs) c ^= 32'h0001_0000;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic drive(input logic [7:0] b);
        @(posedge clk); #1;
        rx_dv_i = 1'b1;
        rx_d_i  = b;
    endtask

    task automatic send_bytes(input int upto, input int stall_at);
        repeat (7) drive(8'h55);
        drive(8'hD5);
        for (int k = 0; k < upto; k++) begin
            if (k - 42 == stall_at)     m_axis_tready = 1'b0;
            if (k - 42 == stall_at + 3) m_axis_tready = 1'b1;
            drive(frm[k]);
        end
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        rx_dv_i = 1'b0;
        rx_d_i  = 8'h00;
        m_axis_tready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic send(input int cut, input int stall_at);
        send_bytes(cut < 0 ? frm.size() : 42 + cut, stall_at);
        end_frame();
    endtask

    task automatic start_case();
        got.delete();
        done0 = done_cnt;
        drop0 = drop_cnt;
    endtask

    task automatic check_frame(input string tag, input bit exp_user, input int exp_len);
        int n;
        n = pay.size();
        chk({tag, "_beats"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            chk({tag, "_beat"}, {got[i][9], got[i][7:0]}, {(i == n - 1), pay[i]});
        if (got.size() > 0) chk({tag, "_tuser"}, got[got.size()-1][8], exp_user);
        chk({tag, "_done"}, 64'(done_cnt - done0), 64'd1);
        chk({tag, "_nodrop"}, 64'(drop_cnt - drop0), 64'd0);
        chk({tag, "_len"}, payload_bytes_o, 64'(exp_len));
        chk({tag, "_hmac"}, host_mac_o, src_mac);
        chk({tag, "_hip"}, host_ip_o, src_ip);
        chk({tag, "_hport"}, host_port_o, src_port);
    endtask

    task automatic check_dropped(input string tag);
        chk({tag, "_beats"}, 64'(got.size()), 64'd0);
        chk({tag, "_drop"}, 64'(drop_cnt - drop0), 64'd1);
        chk({tag, "_nodone"}, 64'(done_cnt - done0), 64'd0);
    endtask

    initial begin
        int j, ok, nlast;
        rstn_i = 1'b0; rx_dv_i = 1'b0; rx_er_i = 1'b0; rx_d_i = 8'h00;
        m_axis_tready = 1'b1;
        fpga_mac  = {16'($urandom), $urandom} & 48'hFEFF_FFFF_FFFF;
        fpga_ip   = $urandom;
        fpga_port = 16'($urandom_range(1024, 60000));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tuser", m_axis_tuser, 1'b0);
        chk("rst_hmac", host_mac_o, 48'h0);
        chk("rst_len", payload_bytes_o, 64'd0);
        chk("rst_drop", drop_o, 1'b0);
        chk("rst_done", frame_done_o, 1'b0);
        rstn_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Nominal frame, payload 0x00..0x0F
        build(fpga_mac, fpga_ip, fpga_port, 8'h11, 16, 0, 1'b0, 1'b0);
        start_case(); send(-1, NO_STALL); check_frame("basic", 1'b0, 16);

        // Wrong destination port, then a good random frame
        build(fpga_mac, fpga_ip, fpga_port + 16'd1, 8'h11, 16, 0, 1'b0, 1'b0);
        start_case(); send(-1, NO_STALL); check_dropped("badport");
        build(fpga_mac, fpga_ip, fpga_port, 8'h11, $urandom_range(1, 40), 0, 1'b1, 1'b0);
        start_case(); send(-1, NO_STALL); check_frame("after_drop", 1'b0, pay.size());

        // Corrupted FCS
        build(fpga_mac, fpga_ip, fpga_port, 8'h11, 20, 0, 1'b1, 1'b1);
        start_case(); send(-1, NO_STALL); check_frame("badfcs", 1'b1, 20);

        // Broadcast with padding
        build(48'hFFFF_FFFF_FFFF, fpga_ip, fpga_port, 8'h11, 4, 14, 1'b1, 1'b0);
        start_case(); send(-1, NO_STALL); check_frame("bcast_pad", 1'b0, 4);

        // Truncated after 5 of 16 payload bytes
        build(fpga_mac, fpga_ip, fpga_port, 8'h11, 16, 0, 1'b1, 1'b0);
        start_case(); send(5, NO_STALL);
        while (pay.size() > 5) void'(pay.pop_back());
        check_frame("trunc", 1'b1, 16);

        // Sink stalls for 3 byte-times: beats must be an in-order subset, flagged
        build(fpga_mac, fpga_ip, fpga_port, 8'h11, 32, 0, 1'b0, 1'b0);
        start_case(); send(-1, 10);
        ok = 1; j = 0; nlast = 0;
        foreach (got[i]) begin
            while (j < pay.size() && pay[j] != got[i][7:0]) j++;
            if (j >= pay.size()) ok = 0;
            j++;
            if (got[i][9]) nlast++;
        end
        chk("stall_subseq", 64'(ok), 64'd1);
        chk("stall_short", 64'(got.size() < 32), 64'd1);
        chk("stall_one_last", 64'(nlast), 64'd1);
        if (got.size() > 0) chk("stall_end", got[got.size()-1][9:8], 2'b11);
        chk("stall_done", 64'(done_cnt - done0), 64'd1);

        // Filter rejections, one field wrong at a time, plus oversize length
        for (int v = 0; v < 4; v++) begin
            case (v)
                0: build(fpga_mac ^ 48'h1, fpga_ip, fpga_port, 8'h11, 8, 0, 1'b1, 1'b0);
                1: build(fpga_mac, fpga_ip ^ 32'h100, fpga_port, 8'h11, 8, 0, 1'b1, 1'b0);
                2: build(fpga_mac, fpga_ip, fpga_port, 8'h06, 8, 0, 1'b1, 1'b0);
                default: build(fpga_mac, fpga_ip, fpga_port, 8'h11, 2048, 0, 1'b1, 1'b0);
            endcase
            start_case(); send(-1, NO_STALL); check_dropped($sformatf("filter%0d", v));
        end

        // Largest accepted payload
        build(fpga_mac, fpga_ip, fpga_port, 8'h11, 2047, 0, 1'b1, 1'b0);
        start_case(); send(-1, NO_STALL); check_frame("maxlen", 1'b0, 2047);

        // Reset in the middle of the payload
        build(fpga_mac, fpga_ip, fpga_port, 8'h11, 16, 0, 1'b1, 1'b0);
        start_case(); send_bytes(42 + 8, NO_STALL);
        @(posedge clk); #1;
        rstn_i = 1'b0; rx_dv_i = 1'b0; rx_d_i = 8'h00;
        #1;
        chk("midrst_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst_hmac", host_mac_o, 48'h0);
        chk("midrst_len", payload_bytes_o, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        nlast = 0;
        foreach (got[i]) if (got[i][9]) nlast++;
        chk("midrst_no_tlast", 64'(nlast), 64'd0);
        chk("midrst_no_done", 64'(done_cnt - done0), 64'd0);
        build(fpga_mac, fpga_ip, fpga_port, 8'h11, 12, 0, 1'b1, 1'b0);
        start_case(); send(-1, NO_STALL); check_frame("post_rst", 1'b0, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
